tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

Round-robin arbiter and sequencer for a shared tristate bus. Up to N requesters each drive the bus through their own tristate buffer. The block produces the one-hot output-enable (`c`) for those buffers and guarantees that no two enables are ever high in the same cycle. It inserts a programmable all-off turnaround gap between owners and forcibly reclaims the bus from any owner that holds it past a hold limit.

## Interface
- N, default 4: number of requesters (2..16).
- MAX_HOLD, default 8: maximum consecutive grant cycles per tenure (1..255).
- TURN_CYC, default 1: number of all-enables-off cycles between tenures (1..15).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised by the integrator.
- req  input  N  per-requester bus request, level; held high while the requester wants the bus.
- oe  output  N  one-hot-or-zero enables, connected to the `c` input of each requester's tristate buffer.
- gnt_id  output  clog2(N)  index of the current owner; 0 when no owner.
- busy  output  1  high while any `oe` bit is high.
- timeout  output  1  one-cycle pulse on the cycle a tenure is ended by MAX_HOLD.

## Operation
- All outputs are registered.
- Reset values: `oe`=0, `gnt_id`=0, `busy`=0, `timeout`=0, state=IDLE, rr pointer=0, hold and turn counters=0.
- State IDLE:
  - `oe`=0.
  - At a clock edge where `req`≠0, pick the winner: the first set bit of `req` searching upward from the rr pointer, with wrap-around.
  - Go to GRANT with `oe`=1<<winner, `gnt_id`=winner, hold count=1, rr pointer=(winner+1) mod N.
- State GRANT (owner k):
  - At each edge, if `req[k]`=0, go to TURN and drive `oe`=0. This is a normal release.
  - Otherwise, if hold count = MAX_HOLD, go to TURN, drive `oe`=0, and pulse `timeout` for exactly the first TURN cycle.
  - Otherwise, increment hold count and keep `oe`.
  - Requests from other requesters are ignored during GRANT. There is no preemption other than MAX_HOLD.
- State TURN:
  - `oe`=0 and `gnt_id`=0.
  - The turn counter counts from 1 to TURN_CYC.
  - On the edge ending the last TURN cycle, arbitrate exactly as in IDLE. Go to GRANT if `req`≠0, else to IDLE.
- Fairness:
  - The rr pointer always points past the last owner.
  - A timed-out requester that keeps `req` high has the lowest priority in the next arbitration.
  - Worst-case wait for any requester is (N−1)·(MAX_HOLD+TURN_CYC) cycles plus its own TURN gap.
- Invariant: popcount(`oe`) ≤ 1 in every cycle, including the reset cycle.
- Invariant: between any two distinct nonzero `oe` values there are at least TURN_CYC cycles of `oe`=0.
- `req` bits of index ≥ N do not exist. The search wraps modulo N.

## Timing
- Request-to-enable latency from IDLE is 1 cycle: `req` high at edge t gives `oe` high after edge t.
- Release: `req[k]` low sampled at edge t gives `oe`=0 after edge t. The tristate for k is therefore off one cycle after the requester drops `req`, so the requester must keep its data stable for that cycle.
- Back-to-back tenures: the first `oe` of the next owner appears after exactly TURN_CYC zero cycles.
- A tenure lasts at most MAX_HOLD cycles of `oe` high.
- A request that rises and falls entirely inside a GRANT or TURN interval is not remembered.
- A `req` that drops on the same edge it would be granted is not granted.
- Reset mid-tenure: `oe` goes to 0 asynchronously on `rst_n` low, with no glitch to any other bit. After reset, arbitration restarts from pointer 0.

## Test plan
- Reset and single request:
  - Hold `rst_n` low for 3 cycles: `oe`=0, `busy`=0.
  - Release reset, then raise `req`=4'b0100 for 5 cycles: `oe`=4'b0100 from cycle 1 through 5, then 4'b0000; `gnt_id`=2.
- Round-robin:
  - Hold `req`=4'b1111 constant, with MAX_HOLD=8 and TURN_CYC=1.
  - Required: grants in order 0,1,2,3,0; each lasts 8 cycles; each is followed by 1 zero cycle; `timeout` pulses 4 times.
- Early release:
  - Owner 1 drops `req` after 3 cycles while `req[3]` is pending.
  - Required: `oe`=4'b0010 for 3 cycles, then 0 for 1 cycle, then 4'b1000.
- Turnaround length:
  - Set TURN_CYC=3 and request from both requesters 0 and 1.
  - Required: exactly 3 cycles of `oe`=0 between tenures; `oe` is never 4'b0011.
- Reset mid-tenure:
  - Assert `rst_n` low during cycle 4 of owner 2's tenure.
  - Required: `oe`=0 immediately. After release with `req`=4'b0101, the first grant goes to 0.
- Random stress:
  - Drive 10k cycles of random `req`.
  - Required: assertions that popcount(`oe`) ≤ 1, that the TURN gap ≥ TURN_CYC, that no tenure exceeds MAX_HOLD, and that no requester waits longer than the bound.

Source files
------------

// File: rtl/tristate_bus_arbiter_if.sv
// tristate_bus_arbiter_if: request/enable bundle between the bus requesters and the arbiter.
interface tristate_bus_arbiter_if #(
   parameter int N = 4
);
   logic [N-1:0]         req;
   logic [N-1:0]         oe;
   logic [$clog2(N)-1:0] gnt_id;
   logic                 busy;
   logic                 timeout;
   modport master (input req, output oe, gnt_id, busy, timeout);
   modport slave (output req, input oe, gnt_id, busy, timeout);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner selection for a shared tristate bus,
// with an all-off turnaround gap between owners and a per-tenure hold limit.
module tristate_bus_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int TURN_CYC = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   tristate_bus_arbiter_if.master bus
);
   localparam int W = $clog2(N);
   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] ptr_q, ptr_d, gnt_q, gnt_d, win, win_hi, win_lo;
   logic [7:0]   hold_q, hold_d;
   logic [3:0]   turn_q, turn_d;
   logic [N-1:0] oe_q, oe_d, hi;
   logic         busy_q, to_q, to_d, grab;
   // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
   always_comb begin
      hi = '0;
      win_hi = '0;
      win_lo = '0;
      for (int i = 0; i < N; i++) hi[i] = bus.req[i] & (i >= int'(ptr_q));
      for (int i = N - 1; i >= 0; i--) begin
         if (hi[i]) win_hi = W'(i);
         if (bus.req[i]) win_lo = W'(i);
      end
      win = |hi ? win_hi : win_lo;
   end
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      oe_d    = oe_q;
      to_d    = 1'b0;
      grab    = 1'b0;
      case (state_q)
         IDLE: grab = |bus.req;
         GRANT: begin
            if (!bus.req[gnt_q] || hold_q == 8'(MAX_HOLD)) begin
               state_d = TURN;
               oe_d    = '0;
               gnt_d   = '0;
               hold_d  = '0;
               turn_d  = 4'd1;
               to_d    = bus.req[gnt_q];
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         TURN: begin
            if (turn_q == 4'(TURN_CYC)) begin
               state_d = IDLE;
               turn_d  = '0;
               grab    = |bus.req;
            end else begin
               turn_d = turn_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (grab) begin
         state_d = GRANT;
         oe_d    = N'(1) << win;
         gnt_d   = win;
         hold_d  = 8'd1;
         ptr_d   = (win == W'(N - 1)) ? '0 : win + W'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         hold_q  <= '0;
         turn_q  <= '0;
         oe_q    <= '0;
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
         oe_q    <= oe_d;
         busy_q  <= |oe_d;
         to_q    <= to_d;
      end
   end
   assign bus.oe      = oe_q;
   assign bus.gnt_id  = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = to_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: directed vectors, multi-cycle sequences and a random
// stress run with invariant monitors for the tristate bus arbiter.
module tb_tristate_bus_arbiter;
   localparam int N = 4, MH = 8, TC = 1, TC_B = 3;
   localparam int BOUND = (N - 1) * (MH + TC) + TC;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   stress = 1'b0;
   always #5 clk = ~clk;

   tristate_bus_arbiter_if #(.N(N)) bus_a ();
   tristate_bus_arbiter_if #(.N(N)) bus_b ();
   tristate_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TURN_CYC(TC)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   tristate_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TURN_CYC(TC_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] oe;
      logic [1:0] gnt;
      logic       busy;
      logic       to;
   } vec_t;
   vec_t vec [25];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(string tag, logic [3:0] oe, logic [1:0] g, logic b, logic t);
      chk({tag, " oe"}, 32'(bus_a.oe), 32'(oe));
      chk({tag, " gnt_id"}, 32'(bus_a.gnt_id), 32'(g));
      chk({tag, " busy"}, 32'(bus_a.busy), 32'(b));
      chk({tag, " timeout"}, 32'(bus_a.timeout), 32'(t));
   endtask

   task automatic chk_b(string tag, logic [3:0] oe, logic [1:0] g, logic t);
      chk({tag, " oe"}, 32'(bus_b.oe), 32'(oe));
      chk({tag, " gnt_id"}, 32'(bus_b.gnt_id), 32'(g));
      chk({tag, " timeout"}, 32'(bus_b.timeout), 32'(t));
   endtask

   // Invariant monitors for the random run, sampled mid-cycle.
   logic [3:0] prev_a = '0, prev_b = '0;
   int run_a = 0, zero_a = 0, run_b = 0, zero_b = 0;
   bit seen_a = 1'b0, seen_b = 1'b0;
   int wait_a [N] = '{default: 0};
   always @(negedge clk) begin
      if (stress) begin
         chk("stress onehot a", 32'($countones(bus_a.oe) <= 1), 1);
         chk("stress busy a", 32'(bus_a.busy), 32'(|bus_a.oe));
         chk("stress gnt a", 32'(bus_a.oe), (bus_a.oe == 0) ? 0 : 32'(1) << bus_a.gnt_id);
         if (bus_a.timeout) chk("stress timeout a", 32'(prev_a != 0 && bus_a.oe == 0 && run_a == MH), 1);
         if (bus_a.oe != 0) begin
            if (prev_a == 0 && seen_a) chk("stress gap a", 32'(zero_a >= TC), 1);
            run_a  = (bus_a.oe == prev_a) ? run_a + 1 : 1;
            zero_a = 0;
            seen_a = 1'b1;
            chk("stress hold a", 32'(run_a <= MH), 1);
         end else begin
            zero_a++;
         end
         for (int i = 0; i < N; i++) begin
            wait_a[i] = (bus_a.req[i] && !bus_a.oe[i]) ? wait_a[i] + 1 : 0;
            chk($sformatf("stress wait a%0d", i), 32'(wait_a[i] <= BOUND), 1);
         end
         prev_a = bus_a.oe;
         chk("stress onehot b", 32'($countones(bus_b.oe) <= 1), 1);
         if (bus_b.oe != 0) begin
            if (prev_b == 0 && seen_b) chk("stress gap b", 32'(zero_b >= TC_B), 1);
            run_b  = (bus_b.oe == prev_b) ? run_b + 1 : 1;
            zero_b = 0;
            seen_b = 1'b1;
            chk("stress hold b", 32'(run_b <= MH), 1);
         end else begin
            zero_b++;
         end
         prev_b = bus_b.oe;
      end
   end

   initial begin
      int pulses;
      vec = '{
         '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
         '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
         '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
         '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
         '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0},
         '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0},
         '{4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0},
         '{4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0},
         '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0},
         '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}
      };
      bus_a.req = '0;
      bus_b.req = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         bus_a.req = vec[i].req;
         tick();
         chk_a($sformatf("vec%0d", i), vec[i].oe, vec[i].gnt, vec[i].busy, vec[i].to);
      end
      // Round-robin with every requester saturating: 0,1,2,3,0, each cut by the hold limit.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus_a.req = 4'b1111;
      pulses = 0;
      for (int t = 0; t < 5; t++) begin
         for (int c = 0; c < MH; c++) begin
            tick();
            pulses += int'(bus_a.timeout);
            chk_a($sformatf("rr t%0d c%0d", t, c), 4'(1 << (t % 4)), 2'(t % 4), 1'b1, 1'b0);
         end
         if (t < 4) begin
            tick();
            pulses += int'(bus_a.timeout);
            chk_a($sformatf("rr gap%0d", t), 4'b0000, 2'd0, 1'b0, 1'b1);
         end
      end
      chk("rr timeout pulses", 32'(pulses), 4);
      bus_a.req = '0;
      // Three-cycle turnaround between owners 0 and 1.
      bus_b.req = 4'b0011;
      for (int t = 0; t < 3; t++) begin
         for (int c = 0; c < MH; c++) begin
            tick();
            chk_b($sformatf("turn t%0d c%0d", t, c), 4'(1 << (t % 2)), 2'(t % 2), 1'b0);
         end
         for (int c = 0; c < TC_B; c++) begin
            tick();
            chk_b($sformatf("turn t%0d gap%0d", t, c), 4'b0000, 2'd0, 1'(c == 0));
         end
      end
      bus_b.req = '0;
      // Asynchronous reset in the fourth cycle of owner 2's tenure.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus_a.req = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk_a($sformatf("pre-reset c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
      end
      #3 rst_n = 1'b0;
      #1 chk_a("async reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      bus_a.req = 4'b0101;
      tick();
      tick();
      chk_a("held reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();
      chk_a("post-reset grant", 4'b0001, 2'd0, 1'b1, 1'b0);
      tick();
      chk_a("post-reset hold", 4'b0001, 2'd0, 1'b1, 1'b0);
      // Random stress: waiting requesters persist, owners drop at random.
      rst_n = 1'b0;
      bus_a.req = '0;
      tick();
      rst_n = 1'b1;
      stress = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         for (int i = 0; i < N; i++) begin
            if (bus_a.oe[i]) bus_a.req[i] = ($urandom_range(3) != 0);
            else if (!bus_a.req[i]) bus_a.req[i] = ($urandom_range(2) == 0);
         end
         bus_b.req = 4'($urandom_range(15));
         tick();
      end
      stress = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
